imem_refill_unit: RTL
=====================

Name: imem_refill_unit

Overview:
- Memory-side refill engine directly upstream of the fetch unit's instruction cache controller.
- Accepts a cache-miss request (miss_cache, ram_address) and fetches one full cache line from the external instruction memory.
- Issues one word request per grant and returns the words in order on mem_word/word_ready.
- Presents exactly the mem_word/word_ready interface the fetch unit consumes.

Parameters:
- ADDR_W, 32, address width; equals `pc_size.
- WORD_W, 32, word width; equals `memory_word.
- LINE_WORDS, 4, words per cache line; power of two, 2..16; must match the icache line size.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  reset; asynchronous, active-low.
- miss_cache  in  1  refill request from the fetch unit; held high until the line is filled.
- ram_address  in  ADDR_W  miss address from the fetch unit; any byte offset.
- mem_word  out  WORD_W  returned instruction word.
- word_ready  out  1  one-cycle strobe: mem_word is valid.
- busy  out  1  high in every state except IDLE.
- ext_req  out  1  word read request to external memory.
- ext_addr  out  ADDR_W  word address of the current request.
- ext_gnt  in  1  request accepted this cycle (valid only while ext_req=1).
- ext_rdata  in  WORD_W  read data.
- ext_rvalid  in  1  ext_rdata valid; responses return in request order, arbitrary latency ≥1 cycle.

Behaviour:
- Reset (nrst=0, async) forces the following, regardless of state:
  - state=IDLE; counters=0.
  - mem_word=0, word_ready=0, busy=0, ext_req=0, ext_addr=0.
- Line base: base = ram_address with the low log2(LINE_WORDS)+2 bits cleared.
  - Latched on the IDLE->FILL transition.
  - ram_address changes after that are ignored until the next IDLE.
- Counters, each log2(LINE_WORDS)+1 bits:
  - iss_cnt counts grants.
  - ret_cnt counts responses.
  - outst = iss_cnt - ret_cnt.
- Request rules:
  - ext_req=1 while in FILL and iss_cnt<LINE_WORDS.
  - ext_addr = base + 4*iss_cnt, registered.
  - On ext_gnt: iss_cnt++ and ext_addr advances the same edge.
  - ext_req and ext_addr stay stable until granted.
- Response rules:
  - On ext_rvalid in FILL: mem_word<=ext_rdata, word_ready<=1 on the next cycle (1-cycle registered latency), ret_cnt++.
  - word_ready=0 in all other cycles.
  - mem_word holds its last value when word_ready=0.
- Simultaneous ext_gnt and ext_rvalid in one cycle: both counters update.
- FSM states: IDLE, FILL, DRAIN, DONE.
  - IDLE: when miss_cache=1, latch base, clear counters, go to FILL.
  - FILL, line complete: ret_cnt reaches LINE_WORDS (last rvalid) -> DONE.
  - FILL, abort: miss_cache=0 before completion (flush/redirect) -> DRAIN. ext_req drops immediately; ungranted requests are never issued.
  - DRAIN: absorb responses for the already-granted requests with word_ready forced to 0; when outst==0 -> DONE. Entering DRAIN with outst==0 goes to DONE on the next edge.
  - DONE: one bubble cycle so the cache controller can drop miss_cache; -> IDLE unconditionally. miss_cache seen in DONE is sampled again in IDLE.
- ext_rvalid in IDLE or DONE is ignored: no word_ready, no counter change.
- ext_gnt while ext_req=0 is ignored.
- Throughput: with zero-wait grants and fixed read latency L, the line completes in LINE_WORDS+L+1 cycles after FILL entry.

Decomposition:
- Add to the constants package:
  - refill_state_t enum {IDLE, FILL, DRAIN, DONE}.
  - `icache_line_words define, used as the LINE_WORDS default by both this block and the icache controller.
- Reuse the existing `pc_size and `memory_word defines.
- No sub-module: the FSM and both counters stay in one module (~200 lines).

Test Plan:
- Reset mid-FILL (after 2 grants): assert nrst=0 asynchronously -> all outputs 0 within the same cycle. Then apply miss_cache=1, ram_address=0x40 -> refill starts from 0x40 with no stale words.
- Basic line, zero-wait gnt, latency 1, miss_cache=1, ram_address=0x0000_0104:
  - ext_addr sequence 0x100, 0x104, 0x108, 0x10C.
  - Four word_ready pulses carrying the rdata values in order.
  - DONE lasts one cycle, busy drops, no further ext_req.
- Backpressure: ext_gnt low for 3 cycles on the second request -> ext_req and ext_addr=0x104 held stable; words still returned in order; total of 4 word_ready pulses.
- Abort: miss_cache drops after 3 grants and 1 response -> ext_req=0 next cycle; 2 further rvalids produce no word_ready; state goes DRAIN -> DONE -> IDLE.
- Same-cycle grant and response with latency 1 on every beat -> counters stay consistent; exactly LINE_WORDS pulses; line completes in LINE_WORDS+2 cycles from FILL entry.
- Spurious ext_rvalid in IDLE with rdata=0xDEADBEEF -> word_ready stays 0 and mem_word is unchanged. Then miss_cache held high through DONE -> exactly one new refill starts from IDLE.

Source files
------------

// File: rtl/imem_refill_unit_pkg.sv
// Shared constants and types for the instruction-memory refill path.
// The line-size define is also read by the icache controller, so both sides agree on the line geometry.
`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef MEMORY_WORD
`define MEMORY_WORD 32
`endif
`ifndef ICACHE_LINE_WORDS
`define ICACHE_LINE_WORDS 4
`endif

package imem_refill_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } refill_state_t;

endpackage

// File: rtl/imem_refill_unit.sv
// Refills one icache line from external memory, one word request per grant, words returned in order.
// Words appear one cycle after ext_rvalid; requests are held stable until ext_gnt, abort drains granted reads silently.
`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef MEMORY_WORD
`define MEMORY_WORD 32
`endif
`ifndef ICACHE_LINE_WORDS
`define ICACHE_LINE_WORDS 4
`endif

module imem_refill_unit
    import imem_refill_unit_pkg::*;
#(
    parameter int ADDR_W     = `PC_SIZE,
    parameter int WORD_W     = `MEMORY_WORD,
    parameter int LINE_WORDS = `ICACHE_LINE_WORDS
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              miss_cache,
    input  logic [ADDR_W-1:0] ram_address,
    output logic [WORD_W-1:0] mem_word,
    output logic              word_ready,
    output logic              busy,
    output logic              ext_req,
    output logic [ADDR_W-1:0] ext_addr,
    input  logic              ext_gnt,
    input  logic [WORD_W-1:0] ext_rdata,
    input  logic              ext_rvalid
);

    localparam int OFF_W = $clog2(LINE_WORDS) + 2;
    localparam int CNT_W = $clog2(LINE_WORDS) + 1;
    localparam logic [CNT_W-1:0] LINE_CNT = CNT_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);

    refill_state_t     state;
    refill_state_t     state_nx;
    logic [CNT_W-1:0]  iss_cnt;
    logic [CNT_W-1:0]  ret_cnt;
    logic [CNT_W-1:0]  outst;
    logic              gnt_take;
    logic              rsp_fill;
    logic              rsp_take;
    logic [ADDR_W-1:0] line_base;
    logic              unused_offset_bits;

    assign line_base          = {ram_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign unused_offset_bits = ^ram_address[OFF_W-1:0];

    assign outst    = iss_cnt - ret_cnt;
    assign ext_req  = (state == FILL) && (iss_cnt < LINE_CNT);
    assign busy     = (state != IDLE);
    assign gnt_take = ext_req && ext_gnt;
    assign rsp_fill = ext_rvalid && (state == FILL);
    // Responses in DRAIN only count while something is still owed; strays are dropped.
    assign rsp_take = rsp_fill || (ext_rvalid && (state == DRAIN) && (outst != '0));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (miss_cache) state_nx = FILL;
            FILL: begin
                if (rsp_fill && (ret_cnt == LAST_CNT)) state_nx = DONE;
                else if (!miss_cache)                  state_nx = DRAIN;
            end
            DRAIN: if (outst == '0) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            iss_cnt    <= '0;
            ret_cnt    <= '0;
            ext_addr   <= '0;
            mem_word   <= '0;
            word_ready <= 1'b0;
        end else begin
            state      <= state_nx;
            word_ready <= rsp_fill;
            if (rsp_fill) mem_word <= ext_rdata;
            // ext_addr itself carries the latched line base, advanced one word per grant.
            if (state == IDLE) begin
                iss_cnt <= '0;
                ret_cnt <= '0;
                if (miss_cache) ext_addr <= line_base;
            end else begin
                if (gnt_take) begin
                    iss_cnt  <= iss_cnt + CNT_W'(1);
                    ext_addr <= ext_addr + ADDR_W'(4);
                end
                if (rsp_take) ret_cnt <= ret_cnt + CNT_W'(1);
            end
        end
    end

endmodule
